// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the UART peripheral (transmitter and
//   receiver). Frame configuration is encoded identically in both directions
//   so the two blocks interoperate.
//
//   uart_state_t : frame FSM states, Idle -> Start -> Data -> [Parity] ->
//                  Stop1 -> [Stop2]
//   Parity*      : parity_type encodings; bit 1 enables parity, bit 0 selects
//                  odd parity
//   parity_bit() : parity bit value expected for a given byte and encoding
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        Idle,
        Start,
        Data,
        Parity,
        Stop1,
        Stop2
    } uart_state_t;

    localparam logic [1:0] ParityNone = 2'b00;
    localparam logic [1:0] ParityEven = 2'b10;
    localparam logic [1:0] ParityOdd  = 2'b11;

    // Even parity makes the total count of ones even; odd flips that bit.
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] parity_type);
        return (^data) ^ parity_type[0];
    endfunction

endpackage

// File: rtl/register_d.sv
// -----------------------------------------------------------------------------
// register_d
//   Generic D register with load enable and asynchronous active-high reset.
//
//   Parameters : Width    - register width
//                ResetVal - value held while reset is asserted
//   Ports      : clock, reset
//                en_i - load d_i on the next clock edge
//                d_i  - next value
//                q_o  - registered value
// -----------------------------------------------------------------------------
module register_d #(
    parameter int unsigned           Width    = 8,
    parameter logic [Width-1:0]      ResetVal = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] reg_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reg_q <= ResetVal;
        end else if (en_i) begin
            reg_q <= d_i;
        end
    end

    assign q_o = reg_q;

endmodule

// File: rtl/sync_parallel_counter.sv
// -----------------------------------------------------------------------------
// sync_parallel_counter
//   Synchronous up-counter with clear and saturation at MaxVal.
//
//   Parameters : Width  - counter width
//                MaxVal - value at which the counter holds
//   Ports      : clock, reset (asynchronous, active-high)
//                clr_i   - synchronous clear, has priority over en_i
//                en_i    - count up by one unless saturated
//                count_o - current count
// -----------------------------------------------------------------------------
module sync_parallel_counter #(
    parameter int unsigned      Width  = 3,
    parameter logic [Width-1:0] MaxVal = '1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != MaxVal)) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
//   Front end of the UART receiver: 2-flop synchronizer for the asynchronous
//   serial line, oversampling tick counter and mid-bit sample strobe.
//
//   Build option UART_RX_MAJORITY_VOTE_EN: when defined, the bit value is the
//   2-of-3 majority of the synchronized line one cycle before, at and one cycle
//   after the nominal sample point, and the strobe is issued one cycle later so
//   all three samples are available.
//
//   Parameters : OVERSAMPLE - clock cycles per bit (even, >= 4)
//   Ports      : clock, reset (asynchronous, active-high)
//                rxd_i           - raw serial input
//                clr_i           - hold the tick counter at zero (receiver idle)
//                rxd_s_o         - synchronized serial input (2 cycles late)
//                sample_strobe_o - one-cycle pulse at each bit sample point
//                sample_bit_o    - bit value valid with sample_strobe_o
// -----------------------------------------------------------------------------
module uart_rx_sampler #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic rxd_i,
    input  logic clr_i,
    output logic rxd_s_o,
    output logic sample_strobe_o,
    output logic sample_bit_o
);

    localparam int unsigned CntW = $clog2(OVERSAMPLE);
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int unsigned StrobeAt = OVERSAMPLE / 2;
`else
    localparam int unsigned StrobeAt = OVERSAMPLE / 2 - 1;
`endif

    logic [1:0]      sync_q;
    logic [CntW-1:0] tick_q;
    logic [CntW-1:0] tick_d;

    // Reset to the idle level so leaving reset never looks like a start bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd_i};
        end
    end

    assign rxd_s_o = sync_q[1];

    // Modulo-OVERSAMPLE counter; OVERSAMPLE need not be a power of two.
    always_comb begin
        tick_d = tick_q + CntW'(1);
        if (clr_i || (tick_q == CntW'(OVERSAMPLE - 1))) begin
            tick_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign sample_strobe_o = !clr_i && (tick_q == CntW'(StrobeAt));

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] hist_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], sync_q[1]};
        end
    end

    assign sample_bit_o = (hist_q[1] & hist_q[0]) |
                          (hist_q[1] & sync_q[1]) |
                          (hist_q[0] & sync_q[1]);
`else
    assign sample_bit_o = sync_q[1];
`endif

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   UART receiver. Frames: 1 start bit, 8 data bits LSb first, optional parity
//   bit, 1 or 2 stop bits; configured like the transmitter. Runs on a clock of
//   OVERSAMPLE x bit rate and samples each bit at mid-bit. Received bytes are
//   delivered through a one-entry valid/ready buffer.
//
//   Build option UART_RX_MAJORITY_VOTE_EN: 2-of-3 majority per bit, every
//   sample point (and data_valid_o) one cycle later.
//
//   Parameters : OVERSAMPLE - clock cycles per bit (even, >= 4)
//   Ports      : clock, reset (asynchronous, active-high)
//                rx_en_i        - receiver enable; low aborts a frame in flight
//                parity_type_i  - 0/1 none, 2 even, 3 odd
//                nstop_i        - 0 one stop bit, 1 two stop bits
//                rxd_i          - serial input, asynchronous, idles high
//                data_out_o     - held byte
//                data_valid_o   - data_out_o and flags valid
//                data_ready_i   - consumer accepts (transfer on valid & ready)
//                parity_error_o - parity mismatch on the held byte
//                frame_error_o  - a stop bit of the held byte sampled 0
//                overrun_o      - a frame was dropped because the buffer was full
//                rx_busy_o      - FSM not in Idle
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_en_i,
    input  logic [1:0] parity_type_i,
    input  logic       nstop_i,
    input  logic       rxd_i,
    output logic [7:0] data_out_o,
    output logic       data_valid_o,
    input  logic       data_ready_i,
    output logic       parity_error_o,
    output logic       frame_error_o,
    output logic       overrun_o,
    output logic       rx_busy_o
);

    uart_state_t state_q;
    logic        par_err_q;   // pending flags for the frame in flight
    logic        frm_err_q;
    logic        brk_wait_q;  // after a frame error, hold off until the line idles
    logic        done_q;      // frame complete, one cycle after the final stop sample
    logic        busy_q;

    logic       rxd_s;
    logic       sample_strobe;
    logic       sample_bit;
    logic       tick_clr;
    logic       shift_en;
    logic       bit_clr;
    logic [2:0] bit_cnt;
    logic [7:0] shift_q;
    logic [7:0] shift_d;

    logic       handshake;
    logic       load;
    logic       drop;
    logic [1:0] status_q;     // {valid, overrun}
    logic [1:0] status_d;
    logic [1:0] flags_q;      // {parity_error, frame_error}

    // ---------------------------------------------------------------------
    // Sampling front end
    // ---------------------------------------------------------------------
    assign tick_clr = (state_q == Idle);

    uart_rx_sampler #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_sampler (
        .clock           (clock),
        .reset           (reset),
        .rxd_i           (rxd_i),
        .clr_i           (tick_clr),
        .rxd_s_o         (rxd_s),
        .sample_strobe_o (sample_strobe),
        .sample_bit_o    (sample_bit)
    );

    // ---------------------------------------------------------------------
    // Data path: bit index and shift register
    // ---------------------------------------------------------------------
    assign shift_en = sample_strobe && (state_q == Data);
    assign bit_clr  = sample_strobe && (state_q == Start);

    sync_parallel_counter #(
        .Width  (3),
        .MaxVal (3'd7)
    ) u_bit_cnt (
        .clock   (clock),
        .reset   (reset),
        .clr_i   (bit_clr),
        .en_i    (shift_en),
        .count_o (bit_cnt)
    );

    // LSb arrives first, so shift in from the top.
    assign shift_d = {sample_bit, shift_q[7:1]};

    register_d #(
        .Width    (8),
        .ResetVal (8'h00)
    ) u_shift (
        .clock (clock),
        .reset (reset),
        .en_i  (shift_en),
        .d_i   (shift_d),
        .q_o   (shift_q)
    );

    // ---------------------------------------------------------------------
    // Frame FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= Idle;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            brk_wait_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!rx_en_i && (state_q != Idle)) begin
                // Abort: the partial frame is dropped, the output buffer is untouched.
                state_q    <= Idle;
                brk_wait_q <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                unique case (state_q)
                    Idle: begin
                        if (rx_en_i && !rxd_s) begin
                            state_q   <= Start;
                            par_err_q <= 1'b0;
                            frm_err_q <= 1'b0;
                            busy_q    <= 1'b1;
                        end
                    end
                    Start: begin
                        if (sample_strobe) begin
                            if (sample_bit) begin
                                state_q <= Idle;  // false start
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= Data;
                            end
                        end
                    end
                    Data: begin
                        if (sample_strobe && (bit_cnt == 3'd7)) begin
                            state_q <= parity_type_i[1] ? Parity : Stop1;
                        end
                    end
                    Parity: begin
                        if (sample_strobe) begin
                            if (sample_bit != parity_bit(shift_q, parity_type_i)) begin
                                par_err_q <= 1'b1;
                            end
                            state_q <= Stop1;
                        end
                    end
                    Stop1, Stop2: begin
                        if (brk_wait_q) begin
                            if (rxd_s) begin
                                state_q    <= Idle;
                                brk_wait_q <= 1'b0;
                                busy_q     <= 1'b0;
                            end
                        end else if (sample_strobe) begin
                            if (!sample_bit) begin
                                frm_err_q <= 1'b1;
                            end
                            if ((state_q == Stop1) && nstop_i) begin
                                state_q <= Stop2;
                            end else begin
                                done_q <= 1'b1;
                                if (frm_err_q || !sample_bit) begin
                                    // Stay out of Idle so a held-low line is not a new start.
                                    brk_wait_q <= 1'b1;
                                end else begin
                                    state_q <= Idle;
                                    busy_q  <= 1'b0;
                                end
                            end
                        end
                    end
                    default: begin
                        state_q <= Idle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ---------------------------------------------------------------------
    // One-entry output buffer
    // ---------------------------------------------------------------------
    assign handshake = status_q[1] & data_ready_i;
    assign load      = done_q & (~status_q[1] | data_ready_i);
    assign drop      = done_q & status_q[1] & ~data_ready_i;

    always_comb begin
        status_d = status_q;
        if (load) begin
            status_d[1] = 1'b1;
        end else if (handshake) begin
            status_d[1] = 1'b0;
        end
        if (drop) begin
            status_d[0] = 1'b1;
        end else if (handshake) begin
            status_d[0] = 1'b0;
        end
    end

    register_d #(
        .Width    (2),
        .ResetVal (2'b00)
    ) u_status (
        .clock (clock),
        .reset (reset),
        .en_i  (1'b1),
        .d_i   (status_d),
        .q_o   (status_q)
    );

    register_d #(
        .Width    (8),
        .ResetVal (8'h00)
    ) u_data_buf (
        .clock (clock),
        .reset (reset),
        .en_i  (load),
        .d_i   (shift_q),
        .q_o   (data_out_o)
    );

    register_d #(
        .Width    (2),
        .ResetVal (2'b00)
    ) u_flag_buf (
        .clock (clock),
        .reset (reset),
        .en_i  (load),
        .d_i   ({par_err_q, frm_err_q}),
        .q_o   (flags_q)
    );

    assign data_valid_o   = status_q[1];
    assign overrun_o      = status_q[0];
    assign parity_error_o = flags_q[1];
    assign frame_error_o  = flags_q[0];
    assign rx_busy_o      = busy_q;

endmodule
